// File: rtl/chimera_widemem_bypass_ctrl.sv
module chimera_widemem_bypass_ctrl #(
  parameter int unsigned MaxOutstanding = 8,
  parameter int unsigned SettleCycles   = 4,
  parameter logic        BypassRst      = 1'b0,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic            soc_clk_i,
  input  logic            rst_ni,
  input  logic            bypass_req_i,
  input  logic            aw_valid_i,
  output logic            aw_ready_o,
  output logic            aw_valid_o,
  input  logic            aw_ready_i,
  input  logic            ar_valid_i,
  output logic            ar_ready_o,
  output logic            ar_valid_o,
  input  logic            ar_ready_i,
  input  logic            b_valid_i,
  input  logic            b_ready_i,
  input  logic            r_valid_i,
  input  logic            r_ready_i,
  input  logic            r_last_i,
  output logic            widemem_bypass_o,
  output logic            busy_o,
  output logic [CntW-1:0] wr_cnt_o,
  output logic [CntW-1:0] rd_cnt_o
);

  localparam int unsigned SetW = (SettleCycles > 1) ? $clog2(SettleCycles) : 1;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    SWITCH,
    SETTLE
  } state_e;

  state_e            state_q, state_d;
  logic              bypass_q, bypass_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [CntW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [CntW-1:0]   rd_cnt_q, rd_cnt_d;

  logic stall_aw, stall_ar;
  logic aw_fire, ar_fire, b_fire, r_fire;

  // Stall depends only on registered state, never on the valid inputs.
  assign stall_aw = (state_q != IDLE) | (wr_cnt_q == CntW'(MaxOutstanding));
  assign stall_ar = (state_q != IDLE) | (rd_cnt_q == CntW'(MaxOutstanding));

  assign aw_valid_o = aw_valid_i & ~stall_aw;
  assign aw_ready_o = aw_ready_i & ~stall_aw;
  assign ar_valid_o = ar_valid_i & ~stall_ar;
  assign ar_ready_o = ar_ready_i & ~stall_ar;

  assign aw_fire = aw_valid_o & aw_ready_i;
  assign ar_fire = ar_valid_o & ar_ready_i;
  assign b_fire  = b_valid_i & b_ready_i;
  assign r_fire  = r_valid_i & r_ready_i & r_last_i;

  always_comb begin
    wr_cnt_d = wr_cnt_q;
    if (aw_fire && !b_fire) begin
      wr_cnt_d = wr_cnt_q + CntW'(1);
    end else if (b_fire && !aw_fire && (wr_cnt_q != '0)) begin
      wr_cnt_d = wr_cnt_q - CntW'(1);
    end
  end

  always_comb begin
    rd_cnt_d = rd_cnt_q;
    if (ar_fire && !r_fire) begin
      rd_cnt_d = rd_cnt_q + CntW'(1);
    end else if (r_fire && !ar_fire && (rd_cnt_q != '0)) begin
      rd_cnt_d = rd_cnt_q - CntW'(1);
    end
  end

  always_comb begin
    state_d  = state_q;
    bypass_d = bypass_q;
    settle_d = settle_q;
    unique case (state_q)
      IDLE: begin
        if (bypass_req_i != bypass_q) state_d = DRAIN;
      end
      DRAIN: begin
        if (bypass_req_i == bypass_q) begin
          state_d = IDLE;
        end else if ((wr_cnt_q == '0) && (rd_cnt_q == '0)) begin
          state_d = SWITCH;
        end
      end
      SWITCH: begin
        bypass_d = bypass_req_i;
        settle_d = SetW'(SettleCycles - 1);
        state_d  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == '0) begin
          state_d = IDLE;
        end else begin
          settle_d = settle_q - SetW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge soc_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      bypass_q <= BypassRst;
      settle_q <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      bypass_q <= bypass_d;
      settle_q <= settle_d;
      wr_cnt_q <= wr_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign widemem_bypass_o = bypass_q;
  assign busy_o           = (state_q != IDLE);
  assign wr_cnt_o         = wr_cnt_q;
  assign rd_cnt_o         = rd_cnt_q;

  a_no_b_underflow : assert property (@(posedge soc_clk_i) disable iff (!rst_ni)
    (b_fire && !aw_fire) |-> (wr_cnt_q != '0));
  a_no_r_underflow : assert property (@(posedge soc_clk_i) disable iff (!rst_ni)
    (r_fire && !ar_fire) |-> (rd_cnt_q != '0));

endmodule

// File: tb/tb_chimera_widemem_bypass_ctrl.sv
module tb_chimera_widemem_bypass_ctrl;

  localparam int MAXO   = 8;
  localparam int SETTLE = 4;
  localparam int CNTW   = $clog2(MAXO + 1);

  logic clk, rst_n, req;
  logic awv, awr_i, arv, arr_i, bv, br, rv, rr, rl;
  logic aw_ready_o, aw_valid_o, ar_ready_o, ar_valid_o;
  logic bypass_o, busy_o;
  logic [CNTW-1:0] wr_cnt_o, rd_cnt_o;

  int errs   = 0;
  int checks = 0;

  chimera_widemem_bypass_ctrl #(
    .MaxOutstanding(MAXO),
    .SettleCycles  (SETTLE),
    .BypassRst     (1'b0)
  ) dut (
    .soc_clk_i       (clk),
    .rst_ni          (rst_n),
    .bypass_req_i    (req),
    .aw_valid_i      (awv),
    .aw_ready_o      (aw_ready_o),
    .aw_valid_o      (aw_valid_o),
    .aw_ready_i      (awr_i),
    .ar_valid_i      (arv),
    .ar_ready_o      (ar_ready_o),
    .ar_valid_o      (ar_valid_o),
    .ar_ready_i      (arr_i),
    .b_valid_i       (bv),
    .b_ready_i       (br),
    .r_valid_i       (rv),
    .r_ready_i       (rr),
    .r_last_i        (rl),
    .widemem_bypass_o(bypass_o),
    .busy_o          (busy_o),
    .wr_cnt_o        (wr_cnt_o),
    .rd_cnt_o        (rd_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: mode, outstanding counts, draining flag and a countdown
  // that covers the switch cycle plus the settle window.
  int m_mode, m_wr, m_rd, m_countdown;
  bit m_draining;

  function automatic bit m_busy();
    return m_draining || (m_countdown > 0);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_wr = 0; m_rd = 0; m_countdown = 0; m_draining = 0;
    end else begin
      int  old_wr, old_rd;
      bit  sw, sr, awf, arf, bf, rf;
      old_wr = m_wr; old_rd = m_rd;
      sw  = m_busy() || (m_wr == MAXO);
      sr  = m_busy() || (m_rd == MAXO);
      awf = awv && awr_i && !sw;
      arf = arv && arr_i && !sr;
      bf  = bv && br;
      rf  = rv && rr && rl;
      m_wr = m_wr + int'(awf) - int'(bf); if (m_wr < 0) m_wr = 0;
      m_rd = m_rd + int'(arf) - int'(rf); if (m_rd < 0) m_rd = 0;
      if (m_countdown > 0) begin
        if (m_countdown == SETTLE + 1) m_mode = int'(req);
        m_countdown--;
      end else if (m_draining) begin
        if (int'(req) == m_mode) m_draining = 0;
        else if (old_wr == 0 && old_rd == 0) begin
          m_draining  = 0;
          m_countdown = SETTLE + 1;
        end
      end else if (int'(req) != m_mode) begin
        m_draining = 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit sw, sr;
    sw = m_busy() || (m_wr == MAXO);
    sr = m_busy() || (m_rd == MAXO);
    chk("m_bypass", 32'(bypass_o), 32'(m_mode));
    chk("m_busy",   32'(busy_o),   32'(m_busy()));
    chk("m_wr_cnt", 32'(wr_cnt_o), 32'(m_wr));
    chk("m_rd_cnt", 32'(rd_cnt_o), 32'(m_rd));
    chk("m_aw_valid", 32'(aw_valid_o), 32'(awv && !sw));
    chk("m_aw_ready", 32'(aw_ready_o), 32'(awr_i && !sw));
    chk("m_ar_valid", 32'(ar_valid_o), 32'(arv && !sr));
    chk("m_ar_ready", 32'(ar_ready_o), 32'(arr_i && !sr));
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n = 1'b0; req = 1'b0;
    awv = 1'b0; arv = 1'b0; bv = 1'b0; rv = 1'b0; rl = 1'b0;
    awr_i = 1'b1; arr_i = 1'b1; br = 1'b1; rr = 1'b1;
    #8;
    chk("rst_bypass", 32'(bypass_o), 0);
    chk("rst_busy",   32'(busy_o),   0);
    chk("rst_wr",     32'(wr_cnt_o), 0);
    chk("rst_rd",     32'(rd_cnt_o), 0);
    #4 rst_n = 1'b1;

    // mode request with no traffic
    req = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i == 1) chk("lat_busy_c0", 32'(busy_o), 1);
      if (i == 2) chk("lat_byp_c1", 32'(bypass_o), 0);
      if (i == 3) chk("lat_byp_c2", 32'(bypass_o), 1);
      if (i == 6) chk("lat_busy_c5", 32'(busy_o), 1);
      if (i == 7) begin
        chk("lat_busy_c6", 32'(busy_o), 0);
        chk("lat_awrdy_c6", 32'(aw_ready_o), 1);
      end
    end

    // drain 3 AW / 2 AR before switching back
    awv = 1'b1; arv = 1'b1;
    step(); step(); arv = 1'b0;
    step(); awv = 1'b0;
    chk("drn_wr3", 32'(wr_cnt_o), 3);
    chk("drn_rd2", 32'(rd_cnt_o), 2);
    req = 1'b0;
    step();
    awv = 1'b1; arv = 1'b1;
    #1;
    chk("drn_awrdy", 32'(aw_ready_o), 0);
    chk("drn_arrdy", 32'(ar_ready_o), 0);
    chk("drn_awv",   32'(aw_valid_o), 0);
    step(); step();
    awv = 1'b0; arv = 1'b0;
    chk("drn_wr_held", 32'(wr_cnt_o), 3);
    chk("drn_no_sw",   32'(bypass_o), 1);
    bv = 1'b1; rv = 1'b1; rl = 1'b1;
    step(); step(); rv = 1'b0;
    step(); bv = 1'b0;
    chk("drn_wr0",   32'(wr_cnt_o), 0);
    chk("drn_byp_a", 32'(bypass_o), 1);
    step();
    chk("drn_byp_b", 32'(bypass_o), 1);
    step();
    chk("drn_switched", 32'(bypass_o), 0);
    repeat (4) step();
    chk("drn_idle", 32'(busy_o), 0);

    // counter limit and same-cycle aw/b
    awv = 1'b1;
    repeat (5) step();
    bv = 1'b1;
    step();
    chk("same_cyc_wr5", 32'(wr_cnt_o), 5);
    bv = 1'b0;
    repeat (3) step();
    chk("lim_wr8", 32'(wr_cnt_o), 8);
    chk("lim_awv0", 32'(aw_valid_o), 0);
    bv = 1'b1;
    #1 chk("lim_awv0_bfire", 32'(aw_valid_o), 0);
    step();
    bv = 1'b0;
    chk("lim_wr7", 32'(wr_cnt_o), 7);
    #1 chk("lim_awv_rel", 32'(aw_valid_o), 1);
    step();
    awv = 1'b0;
    chk("lim_wr8b", 32'(wr_cnt_o), 8);
    bv = 1'b1;
    repeat (8) step();
    bv = 1'b0;
    chk("lim_wr_empty", 32'(wr_cnt_o), 0);

    // abort from DRAIN
    awv = 1'b1;
    step(); step();
    awv = 1'b0;
    req = 1'b1;
    step();
    chk("abt_busy", 32'(busy_o), 1);
    step();
    req = 1'b0;
    step();
    chk("abt_idle",  32'(busy_o),     0);
    chk("abt_byp",   32'(bypass_o),   0);
    chk("abt_awrdy", 32'(aw_ready_o), 1);
    chk("abt_wr2",   32'(wr_cnt_o),   2);
    bv = 1'b1;
    step(); step();
    bv = 1'b0;

    // multi-beat read
    arv = 1'b1;
    step();
    arv = 1'b0;
    rv = 1'b1; rl = 1'b0;
    repeat (3) step();
    chk("mb_rd1", 32'(rd_cnt_o), 1);
    rl = 1'b1;
    step();
    rv = 1'b0;
    chk("mb_rd0", 32'(rd_cnt_o), 0);

    // async reset mid-SETTLE
    req = 1'b1;
    repeat (4) step();
    chk("ars_pre_byp",  32'(bypass_o), 1);
    chk("ars_pre_busy", 32'(busy_o),   1);
    req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("ars_byp",   32'(bypass_o),   0);
    chk("ars_busy",  32'(busy_o),     0);
    chk("ars_wr",    32'(wr_cnt_o),   0);
    chk("ars_rd",    32'(rd_cnt_o),   0);
    chk("ars_awrdy", 32'(aw_ready_o), 1);
    step();
    rst_n = 1'b1;
    step();
    chk("ars_post_idle", 32'(busy_o), 0);
    repeat (2) step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
